// File: rtl/stream_demux_onehot_if.sv
// Stream demux bus bundle: one input stream with a one-hot select, NUM_CH
// output channels that share a data bus, plus drop reporting.
interface stream_demux_onehot_if #(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  // Input stream
  logic [DATA_W-1:0] a_i;
  logic [NUM_CH-1:0] sel_i;
  logic              valid_i;
  logic              ready_o;

  // Output channels (data shared, valid/ready per channel)
  logic [DATA_W-1:0] y_o;
  logic [NUM_CH-1:0] y_valid_o;
  logic [NUM_CH-1:0] y_ready_i;

  // Drop reporting
  logic              err_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  // Environment side: drives the input stream and the consumer readies.
  modport master (
    output a_i, sel_i, valid_i, y_ready_i,
    input  ready_o, y_o, y_valid_o, err_o, drop_cnt_o
  );

  // Demux side.
  modport slave (
    input  a_i, sel_i, valid_i, y_ready_i,
    output ready_o, y_o, y_valid_o, err_o, drop_cnt_o
  );
endinterface

// File: rtl/stream_demux_onehot.sv
// Registered 1-to-NUM_CH stream demultiplexer.
// A single output register holds one beat and presents it on the channel
// named by its one-hot select until that channel's consumer takes it.
// Beats with a zero or multi-hot select are accepted, discarded, flagged
// with a one-cycle err_o pulse and counted in a saturating drop counter.
module stream_demux_onehot #(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,   // asynchronous, active-low
  stream_demux_onehot_if.slave  bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] y_reg, y_next;
  logic [NUM_CH-1:0] chan_reg, chan_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [NUM_CH-1:0] y_valid;
  logic [NUM_CH-1:0] chan_hit;
  logic              out_xfer;
  logic              in_xfer;
  logic              in_ready;
  logic              sel_nonzero;
  logic              sel_single;
  logic              sel_legal;

  // Per-channel presentation: a channel is valid only while holding a beat
  // and only if it is the latched destination. chan_hit marks the channel
  // whose consumer is actually taking the beat; readies on other channels
  // are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign y_valid[gi]  = (state_reg == FULL) & chan_reg[gi];
      assign chan_hit[gi] = y_valid[gi] & bus.y_ready_i[gi];
    end
  endgenerate

  assign out_xfer = |chan_hit;

  // Ready is combinational on the output handshake so a draining beat can be
  // replaced in the same cycle without a bubble.
  assign in_ready = (state_reg == EMPTY) | out_xfer;
  assign in_xfer  = bus.valid_i & in_ready;

  // One-hot test: nonzero, and clearing the lowest set bit leaves nothing.
  assign sel_nonzero = |bus.sel_i;
  assign sel_single  = ~|(bus.sel_i & (bus.sel_i - NUM_CH'(1)));
  assign sel_legal   = sel_nonzero & sel_single;

  // Next-state, next-data and drop bookkeeping.
  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    chan_next  = chan_reg;
    err_next   = 1'b0;
    cnt_next   = cnt_reg;

    if (in_xfer && sel_legal) begin
      // New beat loaded; covers both EMPTY->FULL and FULL->FULL replacement.
      state_next = FULL;
      y_next     = bus.a_i;
      chan_next  = bus.sel_i;
    end else if (in_xfer) begin
      // Illegal select: consume and discard. An in_xfer while FULL implies
      // the held beat is draining this cycle, so the register ends up empty
      // either way. Data and channel keep their old contents.
      state_next = EMPTY;
      err_next   = 1'b1;
      if (cnt_reg != {CNT_W{1'b1}}) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (out_xfer) begin
      state_next = EMPTY;
    end
  end

  // State and datapath registers; a beat held at reset is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= EMPTY;
      y_reg     <= '0;
      chan_reg  <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      chan_reg  <= chan_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.ready_o    = in_ready;
  assign bus.y_o        = y_reg;
  assign bus.y_valid_o  = y_valid;
  assign bus.err_o      = err_reg;
  assign bus.drop_cnt_o = cnt_reg;

endmodule
